// File: rtl/otter_io_pkg.sv
// Shared OTTER MMIO definitions: the I/O base address, the posted-write
// record, and the peripheral addresses the MCU already uses.
package otter_io_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;
  localparam logic [31:0] LEDS_ADDR       = 32'h1100_0020;
  localparam logic [31:0] SSEG_ADDR       = 32'h1100_0040;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } io_wr_t;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Generic FIFO bookkeeping: read/write pointers with an extra wrap bit,
// occupancy, and full/empty. Push and pop legality are the caller's job.
module sync_fifo_ptr #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  output logic [PW-2:0] wr_idx_o,
  output logic [PW-2:0] rd_idx_o,
  output logic [PW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Pointers run mod 2*DEPTH, so the plain difference is the occupancy.
  assign count_o  = wr_ptr_q - rd_ptr_q;
  assign full_o   = (count_o == PW'(DEPTH));
  assign empty_o  = (count_o == '0);
  assign wr_idx_o = wr_ptr_q[PW-2:0];
  assign rd_idx_o = rd_ptr_q[PW-2:0];

endmodule

// File: rtl/iobus_wr_buffer.sv
// Posted-write buffer between the OTTER MEM stage and the peripheral fabric:
// MMIO stores are queued and drained in order over valid/ready.
module iobus_wr_buffer
  import otter_io_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     RESET_N,
  input  logic [31:0]              IOBUS_ADDR,
  input  logic [31:0]              IOBUS_OUT,
  input  logic                     IOBUS_WR,
  input  logic                     OVF_CLR,
  output logic                     PER_VALID,
  input  logic                     PER_READY,
  output logic [31:0]              PER_ADDR,
  output logic [31:0]              PER_DATA,
  output logic                     IO_FULL,
  output logic                     IO_IDLE,
  output logic [$clog2(DEPTH):0]   IO_COUNT,
  output logic                     WR_OVF
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-2:0] wr_idx, rd_idx;
  logic [PW-1:0] count;
  logic          full, empty;
  logic          is_mmio, acc, deq, ovf_set;
  logic          ovf_q, ovf_d;
  io_wr_t        mem_q [DEPTH];
  io_wr_t        head;

  assign is_mmio = (IOBUS_ADDR >= IO_BASE);
  assign deq     = !empty && PER_READY;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign acc     = IOBUS_WR && is_mmio && (!full || deq);
  assign ovf_set = IOBUS_WR && is_mmio && full && !deq;

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst_n    (RESET_N),
    .push_i   (acc),
    .pop_i    (deq),
    .wr_idx_o (wr_idx),
    .rd_idx_o (rd_idx),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  always_ff @(posedge clk) begin
    if (acc) begin
      mem_q[wr_idx] <= '{addr: IOBUS_ADDR, data: IOBUS_OUT};
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (OVF_CLR) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  // Storage is never reset, so mask the head to zero while empty.
  assign head      = empty ? '0 : mem_q[rd_idx];
  assign PER_VALID = !empty;
  assign PER_ADDR  = head.addr;
  assign PER_DATA  = head.data;
  assign IO_FULL   = full;
  assign IO_IDLE   = empty;
  assign IO_COUNT  = count;
  assign WR_OVF    = ovf_q;

endmodule

// File: tb/tb_iobus_wr_buffer.sv
// Directed bench for iobus_wr_buffer; a negedge monitor checks every
// peripheral handshake against a queue of expected writes.
module tb_iobus_wr_buffer;
  import otter_io_pkg::*;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT;
  logic        IOBUS_WR, OVF_CLR, PER_READY;
  logic        PER_VALID, IO_FULL, IO_IDLE, WR_OVF;
  logic [31:0] PER_ADDR, PER_DATA;
  logic [2:0]  IO_COUNT;

  int     n_vec = 0;
  int     n_err = 0;
  io_wr_t exp_q[$];

  iobus_wr_buffer #(.DEPTH(4), .IO_BASE(IO_BASE_DEFAULT)) dut (
    .clk        (clk),
    .RESET_N    (RESET_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .OVF_CLR    (OVF_CLR),
    .PER_VALID  (PER_VALID),
    .PER_READY  (PER_READY),
    .PER_ADDR   (PER_ADDR),
    .PER_DATA   (PER_DATA),
    .IO_FULL    (IO_FULL),
    .IO_IDLE    (IO_IDLE),
    .IO_COUNT   (IO_COUNT),
    .WR_OVF     (WR_OVF)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input bit expect_acc);
    IOBUS_WR   = 1'b1;
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    if (expect_acc) exp_q.push_back('{addr: a, data: d});
  endtask

  // Monitor: a handshake completes on the next rising edge whenever
  // valid and ready are both high at the falling edge.
  initial begin
    io_wr_t e;
    forever begin
      @(negedge clk);
      if (RESET_N === 1'b1 && PER_VALID === 1'b1 && PER_READY === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_handshake: got %h_%h, expected none", PER_ADDR, PER_DATA);
        end else begin
          e = exp_q.pop_front();
          check("drain_head", {PER_ADDR, PER_DATA}, {e.addr, e.data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_N = 1'b0; IOBUS_WR = 1'b0; IOBUS_ADDR = '0; IOBUS_OUT = '0;
    OVF_CLR = 1'b0; PER_READY = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 RESET_N = 1'b1;
    @(negedge clk);
    check("rst_idle",  64'(IO_IDLE), 64'd1);
    check("rst_count", 64'(IO_COUNT), 64'd0);
    check("rst_valid", 64'(PER_VALID), 64'd0);
    check("rst_ovf",   64'(WR_OVF), 64'd0);
    check("rst_head",  {PER_ADDR, PER_DATA}, 64'd0);
    cyc(); PER_READY = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    check("idle_ready_valid", 64'(PER_VALID), 64'd0);
    check("idle_ready_count", 64'(IO_COUNT), 64'd0);

    // Single write, held for 5 cycles, then drained
    cyc(); PER_READY = 1'b0;
    drive_wr(LEDS_ADDR, 32'h0000_00A5, 1'b1);
    cyc(); IOBUS_WR = 1'b0;
    @(negedge clk);
    check("single_valid", 64'(PER_VALID), 64'd1);
    check("single_head",  {PER_ADDR, PER_DATA}, {32'h1100_0020, 32'h0000_00A5});
    check("single_count", 64'(IO_COUNT), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      check("hold_head", {31'd0, PER_VALID, PER_ADDR, PER_DATA}, {31'd0, 1'b1, 32'h1100_0020, 32'h0000_00A5});
    end
    cyc(); PER_READY = 1'b1;
    cyc(); PER_READY = 1'b0;
    @(negedge clk);
    check("single_drained_idle", 64'(IO_IDLE), 64'd1);

    // Fill and overflow
    cyc();
    for (int i = 1; i <= 5; i++) begin
      drive_wr(SSEG_ADDR, 32'(i), i <= 4);
      cyc();
      if (i == 4) check("fill_full", 64'(IO_FULL), 64'd1);
    end
    IOBUS_WR = 1'b0;
    @(negedge clk);
    check("ovf_count", 64'(IO_COUNT), 64'd4);
    check("ovf_set",   64'(WR_OVF), 64'd1);
    cyc(); PER_READY = 1'b1;
    repeat (4) cyc();
    PER_READY = 1'b0;
    @(negedge clk);
    check("drain_idle",   64'(IO_IDLE), 64'd1);
    check("drain_all",    64'(exp_q.size()), 64'd0);
    check("ovf_sticky",   64'(WR_OVF), 64'd1);
    cyc(); OVF_CLR = 1'b1;
    cyc(); OVF_CLR = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 64'(WR_OVF), 64'd0);

    // Write-through-full
    cyc();
    for (int i = 1; i <= 4; i++) begin
      drive_wr(SSEG_ADDR, 32'(i), 1'b1);
      cyc();
    end
    drive_wr(SSEG_ADDR, 32'd9, 1'b1);
    PER_READY = 1'b1;
    cyc(); IOBUS_WR = 1'b0; PER_READY = 1'b0;
    @(negedge clk);
    check("wtf_count", 64'(IO_COUNT), 64'd4);
    check("wtf_ovf",   64'(WR_OVF), 64'd0);
    check("wtf_full",  64'(IO_FULL), 64'd1);
    cyc(); PER_READY = 1'b1;
    repeat (4) cyc();
    PER_READY = 1'b0;
    @(negedge clk);
    check("wtf_drain_idle", 64'(IO_IDLE), 64'd1);

    // Address filter, plus the exact-base boundary
    cyc();
    drive_wr(32'h0000_FFFC, 32'h0000_0077, 1'b0);
    cyc(); IOBUS_WR = 1'b0;
    @(negedge clk);
    check("filter_count", 64'(IO_COUNT), 64'd0);
    check("filter_valid", 64'(PER_VALID), 64'd0);
    check("filter_ovf",   64'(WR_OVF), 64'd0);
    cyc();
    drive_wr(IO_BASE_DEFAULT, 32'h0000_0033, 1'b1);
    cyc(); IOBUS_WR = 1'b0;
    @(negedge clk);
    check("base_count", 64'(IO_COUNT), 64'd1);
    cyc(); PER_READY = 1'b1;
    cyc(); PER_READY = 1'b0;

    // Reset mid-operation with 3 entries queued
    for (int i = 1; i <= 3; i++) begin
      drive_wr(LEDS_ADDR, 32'(16 + i), 1'b0);
      cyc();
    end
    IOBUS_WR = 1'b0;
    @(negedge clk);
    check("pre_rst_count", 64'(IO_COUNT), 64'd3);
    #2 RESET_N = 1'b0;
    #1;
    check("async_rst_valid", 64'(PER_VALID), 64'd0);
    check("async_rst_count", 64'(IO_COUNT), 64'd0);
    check("async_rst_head",  {PER_ADDR, PER_DATA}, 64'd0);
    #1 RESET_N = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'(IO_IDLE), 64'd1);
    check("queue_empty",   64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
